// File: rtl/uart_tx_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler_pkg
//   Shared UART timing constants, helper functions and the scheduler FSM
//   state type. Imported by the scheduler, its arbiter and the benches so
//   everyone derives frame timing the same way.
//   Contents:
//     UART_CLK_FREQ    default system clock in Hz
//     UART_BAUD_RATE   default line rate
//     UART_FRAME_BITS  start + 8 data + stop bits per frame
//     bit_cyc()        clock cycles per UART bit
//     idx_width()      index width for N items, never below 1
//     sched_state_t    scheduler FSM states
// ---------------------------------------------------------------------------
package uart_tx_scheduler_pkg;

  localparam int UART_CLK_FREQ   = 100_000_000;
  localparam int UART_BAUD_RATE  = 9600;
  localparam int UART_FRAME_BITS = 10;

  // Whole clock cycles spent on one bit at the given line rate.
  function automatic int bit_cyc(input int freq, input int baud);
    return freq / baud;
  endfunction

  // A single requester still needs a 1-bit index so ports never vanish.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } sched_state_t;

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. Scans the request vector starting at
//   i_ptr and wrapping modulo N; the first set bit wins.
//   Ports:
//     i_req    in   N    pending requests
//     i_ptr    in   PW   requester with highest priority this round
//     o_grant  out  N    one-hot winner (all zero when nothing requests)
//     o_idx    out  PW   binary index of the winner
//     o_any    out  1    at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter
  import uart_tx_scheduler_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  // Walk the requesters in priority order beginning at the pointer. Once a
  // winner is found o_any blocks any later candidate from overriding it, so
  // the loop unrolls into a simple priority chain rotated by i_ptr.
  always_comb begin
    int k;
    k       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int off = 0; off < N; off++) begin
      k = (int'(i_ptr) + off) % N;
      if (!o_any && i_req[k]) begin
        o_any      = 1'b1;
        o_grant[k] = 1'b1;
        o_idx      = PW'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//   Shares one uart_send transmitter between N_REQ byte requesters using
//   round-robin arbitration. uart_send has no ready signal, so every frame
//   is paced by a local down-counter of FRAME_CYC cycles.
//   Ports:
//     clk       in   1        system clock
//     rst       in   1        asynchronous reset, active-high
//     req       in   N_REQ    req[i]=1: requester i has a byte pending
//     req_data  in   8*N_REQ  byte of requester i at [8*i+7:8*i]
//     ack       out  N_REQ    one-cycle pulse: byte of requester i taken
//     tx_valid  out  1        one-cycle start pulse to uart_send
//     tx_data   out  8        byte to uart_send, held until next grant
//     busy      out  1        high while a frame is in flight
//     grant_id  out  GW       index of the most recently granted requester
// ---------------------------------------------------------------------------
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int CLK_FREQ  = UART_CLK_FREQ,
  parameter  int BAUD_RATE = UART_BAUD_RATE,
  parameter  int STOP_GAP  = 0,
  localparam int GW        = idx_width(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     ack,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  output logic                 busy,
  output logic [GW-1:0]        grant_id
);

  localparam int BIT_CYC   = bit_cyc(CLK_FREQ, BAUD_RATE);
  localparam int FRAME_CYC = UART_FRAME_BITS * BIT_CYC + STOP_GAP;
  localparam int CW        = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYC - 1);

  sched_state_t    r_state;
  logic [GW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;

  logic [N_REQ-1:0] w_grant;
  logic [GW-1:0]    w_idx;
  logic             w_any;
  logic [7:0]       w_sel_data;
  logic [GW-1:0]    w_ptr_next;

  rr_arbiter #(
    .N  (N_REQ),
    .PW (GW)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  // Byte of the current winner, and the pointer that hands priority to the
  // requester just after it (wrapping from the last one back to 0).
  always_comb begin
    w_sel_data = req_data[8*int'(w_idx) +: 8];
    if (w_idx == GW'(N_REQ - 1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_idx + GW'(1);
    end
  end

  // Scheduler FSM with registered outputs. IDLE grants the arbiter's winner
  // on the very next edge and loads the frame counter; SEND ignores all
  // requests until the counter has run down, so back-to-back start pulses
  // are FRAME_CYC+1 cycles apart. Reset drops everything at once, which
  // aborts a frame in flight because uart_send is reset by the same line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_ptr    <= '0;
      r_cnt    <= '0;
      ack      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          ack      <= '0;
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          if (w_any) begin
            ack      <= w_grant;
            tx_valid <= 1'b1;
            tx_data  <= w_sel_data;
            grant_id <= w_idx;
            busy     <= 1'b1;
            r_ptr    <= w_ptr_next;
            r_cnt    <= CNT_LOAD;
            r_state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          ack      <= '0;
          tx_valid <= 1'b0;
          if (r_cnt == '0) begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
